// File: rtl/weight_pkg.sv
// Shared constants and FSM encoding for the weight prefetch path
// (weight_fetch producer and weight_pref buffer).
package weight_pkg;

    localparam int N           = 8;
    localparam int ROWS        = 4;
    localparam int COLS        = 8;
    localparam int WG          = 3;
    localparam int ADDR_W      = 10;
    localparam int PE_PER_TILE = ROWS * COLS;
    localparam int DATA_W      = WG * 2 * N;
    localparam int ROW_W       = $clog2(ROWS);
    localparam int COL_W       = $clog2(COLS);
    localparam int IDX_W       = $clog2(PE_PER_TILE);
    localparam int TILE_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILL      = 2'd1,
        ST_SWAP_WAIT = 2'd2,
        ST_DRAIN     = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/weight_fetch_addr_gen.sv
// Tile/PE counters for weight_fetch: produces the SRAM read address and
// the one-cycle-delayed PE row/column that pairs with the returning data.
module weight_fetch_addr_gen
    import weight_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              last_idx,
    output logic [TILE_W-1:0] tiles_done,
    output logic              wr_en,
    output logic [ROW_W-1:0]  wr_row,
    output logic [COL_W-1:0]  wr_col
);

    logic [ADDR_W-1:0] base_q, base_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [ADDR_W-1:0] tile_offset;

    assign last_idx    = (idx_q == IDX_W'(PE_PER_TILE - 1));
    assign tile_offset = ADDR_W'({tile_q, IDX_W'(0)});
    // Address is base + tile*PE_PER_TILE + idx, wrapping naturally at ADDR_W bits.
    assign mem_addr    = rd_en ? (base_q + tile_offset + ADDR_W'(idx_q)) : '0;
    assign tiles_done  = tile_q;
    assign wr_en       = wr_en_q;
    assign wr_row      = wr_idx_q[IDX_W-1:COL_W];
    assign wr_col      = wr_idx_q[COL_W-1:0];

    // Counter advance on each read; delayed index is zeroed when no write follows.
    always_comb begin
        base_d   = base_q;
        idx_d    = idx_q;
        tile_d   = tile_q;
        wr_en_d  = rd_en;
        wr_idx_d = rd_en ? idx_q : '0;
        if (load) begin
            base_d = base_addr;
            idx_d  = '0;
            tile_d = '0;
        end else if (rd_en) begin
            idx_d = idx_q + IDX_W'(1);
            if (last_idx) begin
                tile_d = tile_q + TILE_W'(1);
            end
        end
    end

    // Counter and delay-stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q   <= '0;
            idx_q    <= '0;
            tile_q   <= '0;
            wr_en_q  <= 1'b0;
            wr_idx_q <= '0;
        end else begin
            base_q   <= base_d;
            idx_q    <= idx_d;
            tile_q   <= tile_d;
            wr_en_q  <= wr_en_d;
            wr_idx_q <= wr_idx_d;
        end
    end

endmodule

// File: rtl/weight_fetch.sv
// Weight prefetcher producer: streams weight tiles from SRAM into the idle
// ping-pong buffer and swaps buffers once a tile is written and the SA has
// drained the active one.
module weight_fetch
    import weight_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [TILE_W-1:0] num_tiles,
    input  logic              tile_consumed,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              pref_wr_en,
    output logic [ROW_W-1:0]  pref_wr_row,
    output logic [COL_W-1:0]  pref_wr_col,
    output logic [DATA_W-1:0] pref_wr_data,
    output logic              buf_select,
    output logic              pref_en,
    output logic              busy,
    output logic              done
);

    fetch_state_e      state_q, state_d;
    logic [TILE_W-1:0] num_tiles_q, num_tiles_d;
    logic              buf_select_q, buf_select_d;
    logic              pref_en_q, pref_en_d;
    logic              done_q, done_d;
    logic              consumed_q, consumed_d;
    logic              swapped_q, swapped_d;

    logic              load_job;
    logic              consume_hit;
    logic              consumed_eff;
    logic              last_idx;
    logic [TILE_W-1:0] tiles_done;

    weight_fetch_addr_gen u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (load_job),
        .base_addr  (base_addr),
        .rd_en      (mem_rd_en),
        .mem_addr   (mem_addr),
        .last_idx   (last_idx),
        .tiles_done (tiles_done),
        .wr_en      (pref_wr_en),
        .wr_row     (pref_wr_row),
        .wr_col     (pref_wr_col)
    );

    assign mem_rd_en    = (state_q == ST_FILL);
    // SRAM data passes straight through; masked to zero between writes.
    assign pref_wr_data = pref_wr_en ? mem_rd_data : '0;
    assign buf_select   = buf_select_q;
    assign pref_en      = pref_en_q;
    assign done         = done_q;
    assign busy         = (state_q != ST_IDLE);

    // Next-state logic: job launch, tile fill, buffer swap and drain.
    always_comb begin
        state_d      = state_q;
        num_tiles_d  = num_tiles_q;
        buf_select_d = buf_select_q;
        pref_en_d    = 1'b0;
        done_d       = 1'b0;
        consumed_d   = consumed_q;
        swapped_d    = swapped_q;
        load_job     = 1'b0;
        // A consume pulse only means something once this job has handed a tile over.
        consume_hit  = tile_consumed && swapped_q && (state_q != ST_IDLE);
        consumed_eff = consumed_q || consume_hit;
        if (consume_hit) begin
            consumed_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_job    = 1'b1;
                    num_tiles_d = num_tiles;
                    swapped_d   = 1'b0;
                    consumed_d  = 1'b0;
                    if (num_tiles == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                if (last_idx) begin
                    state_d = ST_SWAP_WAIT;
                end
            end
            ST_SWAP_WAIT: begin
                // First tile needs no drain; later tiles wait for the SA.
                if (!swapped_q || consumed_eff) begin
                    buf_select_d = ~buf_select_q;
                    pref_en_d    = 1'b1;
                    consumed_d   = 1'b0;
                    swapped_d    = 1'b1;
                    state_d      = (tiles_done < num_tiles_q) ? ST_FILL : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (consumed_eff) begin
                    done_d     = 1'b1;
                    consumed_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            num_tiles_q  <= '0;
            buf_select_q <= 1'b0;
            pref_en_q    <= 1'b0;
            done_q       <= 1'b0;
            consumed_q   <= 1'b0;
            swapped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_tiles_q  <= num_tiles_d;
            buf_select_q <= buf_select_d;
            pref_en_q    <= pref_en_d;
            done_q       <= done_d;
            consumed_q   <= consumed_d;
            swapped_q    <= swapped_d;
        end
    end

endmodule

// File: tb/tb_weight_fetch.sv
// Testbench for weight_fetch: scenario tasks with inline checks plus a
// read/write scoreboard fed with expected traffic when each job is launched.
module tb_weight_fetch;
    import weight_pkg::*;

    typedef struct {
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [TILE_W-1:0] num_tiles;
    logic              tile_consumed;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              pref_wr_en;
    logic [ROW_W-1:0]  pref_wr_row;
    logic [COL_W-1:0]  pref_wr_col;
    logic [DATA_W-1:0] pref_wr_data;
    logic              buf_select;
    logic              pref_en;
    logic              busy;
    logic              done;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic exp_bs   = 1'b0;

    logic [ADDR_W-1:0] rd_q[$];
    wr_t               wr_q[$];

    weight_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .base_addr     (base_addr),
        .num_tiles     (num_tiles),
        .tile_consumed (tile_consumed),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rd_data   (mem_rd_data),
        .pref_wr_en    (pref_wr_en),
        .pref_wr_row   (pref_wr_row),
        .pref_wr_col   (pref_wr_col),
        .pref_wr_data  (pref_wr_data),
        .buf_select    (buf_select),
        .pref_en       (pref_en),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [15:0] x;
        x = {6'd0, a};
        return {x * 16'd7 + 16'h1234, ~x, x ^ 16'hA5A5};
    endfunction

    // SRAM model with one-cycle read latency.
    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_word(mem_addr) : '0;
    end

    // Scoreboard: every read and write the DUT issues is matched in order.
    always @(negedge clk) begin
        if (mem_rd_en === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL sb_read unexpected read addr=%h", mem_addr);
            end else begin
                logic [ADDR_W-1:0] ea;
                ea = rd_q.pop_front();
                if (mem_addr !== ea) begin
                    failures++;
                    $display("FAIL sb_read addr got=%h exp=%h", mem_addr, ea);
                end
            end
        end
        if (pref_wr_en === 1'b1) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL sb_write unexpected write row=%0d col=%0d", pref_wr_row, pref_wr_col);
            end else begin
                wr_t ew;
                ew = wr_q.pop_front();
                if (pref_wr_row !== ew.row || pref_wr_col !== ew.col || pref_wr_data !== ew.data) begin
                    failures++;
                    $display("FAIL sb_write got row=%0d col=%0d data=%h exp row=%0d col=%0d data=%h",
                             pref_wr_row, pref_wr_col, pref_wr_data, ew.row, ew.col, ew.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        start         = 1'b0;
        tile_consumed = 1'b0;
    endtask

    task automatic push_job(input logic [ADDR_W-1:0] base, input int n);
        for (int t = 0; t < n; t++) begin
            for (int i = 0; i < PE_PER_TILE; i++) begin
                logic [ADDR_W-1:0] a;
                wr_t w;
                a = ADDR_W'(int'(base) + t * PE_PER_TILE + i);
                rd_q.push_back(a);
                w.row  = ROW_W'(i / COLS);
                w.col  = COL_W'(i % COLS);
                w.data = mem_word(a);
                wr_q.push_back(w);
            end
        end
    endtask

    // Drives start in the current cycle, which becomes cycle 0.
    task automatic launch(input logic [ADDR_W-1:0] base, input logic [TILE_W-1:0] n);
        push_job(base, int'(n));
        base_addr = base;
        num_tiles = n;
        start     = 1'b1;
        cyc       = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({mem_rd_en, mem_addr, pref_wr_en, pref_wr_row, pref_wr_col, pref_wr_data,
             buf_select, pref_en, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_state rd=%b addr=%h wr=%b bs=%b pref_en=%b busy=%b done=%b exp all 0",
                     mem_rd_en, mem_addr, pref_wr_en, buf_select, pref_en, busy, done);
        end
        exp_bs = 1'b0;
    endtask

    task automatic test_single_tile(input logic [ADDR_W-1:0] base);
        launch(base, 8'd1);
        for (int c = 1; c <= 37; c++) begin
            tick();
            if (c == 10) tile_consumed = 1'b1;   // before the first swap: must be ignored
            if (c == 34) exp_bs = ~exp_bs;
            checks++;
            if (mem_rd_en !== (c <= 32) || pref_wr_en !== (c >= 2 && c <= 33) ||
                busy !== 1'b1 || done !== 1'b0 || pref_en !== (c == 34) || buf_select !== exp_bs) begin
                failures++;
                $display("FAIL single_tile cycle=%0d rd=%b wr=%b busy=%b done=%b pref_en=%b bs=%b exp_bs=%b",
                         c, mem_rd_en, pref_wr_en, busy, done, pref_en, buf_select, exp_bs);
            end
        end
        tile_consumed = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || buf_select !== exp_bs) begin
            failures++;
            $display("FAIL single_done done=%b busy=%b bs=%b exp done=1 busy=0 bs=%b", done, busy, buf_select, exp_bs);
        end
        tick();
        checks++;
        if (done !== 1'b0 || rd_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL single_end done=%b rd_left=%0d wr_left=%0d exp 0 0 0", done, rd_q.size(), wr_q.size());
        end
    endtask

    task automatic test_two_tiles(input int consume_cycle, input int swap2_cycle);
        launch(10'h080, 8'd2);
        for (int c = 1; c <= swap2_cycle; c++) begin
            logic er, ew;
            tick();
            if (c == consume_cycle) tile_consumed = 1'b1;
            if (c == 34 || c == swap2_cycle) exp_bs = ~exp_bs;
            er = (c >= 1 && c <= 32) || (c >= 34 && c <= 65);
            ew = (c >= 2 && c <= 33) || (c >= 35 && c <= 66);
            checks++;
            if (mem_rd_en !== er || pref_wr_en !== ew || busy !== 1'b1 || done !== 1'b0 ||
                pref_en !== (c == 34 || c == swap2_cycle) || buf_select !== exp_bs) begin
                failures++;
                $display("FAIL two_tiles consume=%0d cycle=%0d rd=%b wr=%b busy=%b done=%b pref_en=%b bs=%b exp rd=%b wr=%b bs=%b",
                         consume_cycle, c, mem_rd_en, pref_wr_en, busy, done, pref_en, buf_select, er, ew, exp_bs);
            end
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || pref_en !== 1'b0) begin
            failures++;
            $display("FAIL two_tiles_drain busy=%b done=%b pref_en=%b exp 1 0 0", busy, done, pref_en);
        end
        tile_consumed = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || buf_select !== exp_bs || rd_q.size() != 0 || wr_q.size() != 0) begin
            failures++;
            $display("FAIL two_tiles_done done=%b busy=%b bs=%b rd_left=%0d wr_left=%0d exp 1 0 %b 0 0",
                     done, busy, buf_select, rd_q.size(), wr_q.size(), exp_bs);
        end
        tick();
    endtask

    task automatic test_address_wrap();
        launch(10'h3F0, 8'd1);
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 34) exp_bs = ~exp_bs;
            if (c == 16 || c == 17) begin
                logic [ADDR_W-1:0] ea;
                ea = (c == 16) ? 10'h3FF : 10'h000;
                checks++;
                if (mem_addr !== ea || mem_rd_en !== 1'b1) begin
                    failures++;
                    $display("FAIL addr_wrap cycle=%0d addr=%h rd=%b exp addr=%h rd=1", c, mem_addr, mem_rd_en, ea);
                end
            end
        end
        tile_consumed = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || buf_select !== exp_bs || rd_q.size() != 0) begin
            failures++;
            $display("FAIL addr_wrap_done done=%b bs=%b rd_left=%0d exp 1 %b 0", done, buf_select, rd_q.size(), exp_bs);
        end
        tick();
    endtask

    task automatic test_zero_and_busy_start();
        launch(10'h000, 8'd0);
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL zero_tiles cycle=1 done=%b busy=%b rd=%b exp 1 0 0", done, busy, mem_rd_en);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || mem_rd_en !== 1'b0 || buf_select !== exp_bs) begin
            failures++;
            $display("FAIL zero_tiles cycle=2 done=%b busy=%b rd=%b bs=%b exp 0 0 0 %b", done, busy, mem_rd_en, buf_select, exp_bs);
        end
        launch(10'h100, 8'd1);
        for (int c = 1; c <= 34; c++) begin
            tick();
            if (c == 5) begin
                start     = 1'b1;       // ignored: job in progress
                base_addr = 10'h200;
                num_tiles = 8'd5;
            end
            if (c == 34) exp_bs = ~exp_bs;
            checks++;
            if (mem_rd_en !== (c <= 32) || pref_en !== (c == 34) || buf_select !== exp_bs || busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_start cycle=%0d rd=%b pref_en=%b bs=%b busy=%b exp_bs=%b", c, mem_rd_en, pref_en, buf_select, busy, exp_bs);
            end
        end
        tile_consumed = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_start_done done=%b busy=%b exp 1 0", done, busy);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (mem_rd_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_q.size() != 0) begin
                failures++;
                $display("FAIL busy_start_idle rd=%b busy=%b done=%b rd_left=%0d exp 0 0 0 0", mem_rd_en, busy, done, rd_q.size());
            end
        end
    endtask

    task automatic test_reset_mid_fill();
        launch(10'h040, 8'd2);
        for (int c = 1; c <= 10; c++) begin
            tick();
        end
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        exp_bs = 1'b0;
        checks++;
        if ({mem_rd_en, mem_addr, pref_wr_en, pref_wr_row, pref_wr_col, pref_wr_data,
             buf_select, pref_en, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_mid_fill rd=%b addr=%h wr=%b bs=%b pref_en=%b busy=%b done=%b exp all 0",
                     mem_rd_en, mem_addr, pref_wr_en, buf_select, pref_en, busy, done);
        end
        rd_q.delete();
        wr_q.delete();
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (mem_rd_en !== 1'b0 || pref_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL reset_quiet rd=%b wr=%b busy=%b done=%b exp 0 0 0 0", mem_rd_en, pref_wr_en, busy, done);
            end
        end
        test_single_tile(10'h040);
    endtask

    initial begin
        reset         = 1'b1;
        start         = 1'b0;
        tile_consumed = 1'b0;
        base_addr     = '0;
        num_tiles     = '0;
        test_reset();
        test_single_tile(10'h010);
        test_reset_mid_fill();
        test_two_tiles(40, 67);
        test_two_tiles(100, 101);
        test_address_wrap();
        test_zero_and_busy_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
